vga_timing_gen: RTL and testbench

Upstream timing stage for the Pong display path. Derives the 25 MHz pixel enable from CLOCK_50, generates the 800x525 h/v raster counters consumed by the game-logic and draw stages, and emits frame/line ticks for game-state updates. Also serves as the final output stage: it registers the RGB produced by the draw stage, blanks it outside the active area, and aligns HS/VS with the pixel pipeline delay.

---
 rtl/vga_pkg.sv | 62 ++++++
 rtl/vga_sync_delay.sv | 32 +++
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 raster constants, RGB12 field layout and colour-bar helpers
// shared by vga_timing_gen and vga_sync_delay.
package vga_pkg;

  localparam logic [9:0] H_ACTIVE_C     = 10'd640;
  localparam logic [9:0] H_SYNC_START_C = 10'd660;
  localparam logic [9:0] H_SYNC_END_C   = 10'd756;
  localparam logic [9:0] H_TOTAL_C      = 10'd800;
  localparam logic [9:0] V_ACTIVE_C     = 10'd480;
  localparam logic [9:0] V_SYNC_START_C = 10'd494;
  localparam logic [9:0] V_SYNC_END_C   = 10'd495;
  localparam logic [9:0] V_TOTAL_C      = 10'd525;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Per-pixel control bits carried through the delay pipe; sync is active low.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

  localparam logic [9:0] BAR_WIDTH = 10'd80;

  typedef enum logic [2:0] {
    BAR_WHITE,
    BAR_YELLOW,
    BAR_CYAN,
    BAR_GREEN,
    BAR_MAGENTA,
    BAR_RED,
    BAR_BLUE,
    BAR_BLACK
  } bar_t;

  // Past the active width the index wraps, but those pixels are blanked anyway.
  function automatic bar_t bar_index(logic [9:0] h);
    return bar_t'(3'(h / BAR_WIDTH));
  endfunction

  function automatic rgb12_t bar_colour(bar_t bar);
    rgb12_t c;
    case (bar)
      BAR_WHITE:   c = rgb12_t'(12'hFFF);
      BAR_YELLOW:  c = rgb12_t'(12'hFF0);
      BAR_CYAN:    c = rgb12_t'(12'h0FF);
      BAR_GREEN:   c = rgb12_t'(12'h0F0);
      BAR_MAGENTA: c = rgb12_t'(12'hF0F);
      BAR_RED:     c = rgb12_t'(12'hF00);
      BAR_BLUE:    c = rgb12_t'(12'h00F);
      default:     c = rgb12_t'(12'h000);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH-stage shift register advanced only on the pixel enable,
// used to line up sync/blank (and bar index) with the draw-stage latency.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int unsigned      WIDTH     = 3,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: every stage is reset, not just the last one; otherwise stale sync bits
  // would shift out as a partial pulse after a mid-frame reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
    end else if (en_i) begin
      stage_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 25 MHz pixel enable, 800x525 raster counters, line/frame ticks and
// the blanked, sync-aligned VGA output stage. Define VGA_TEST_PATTERN_EN for colour bars.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter logic [9:0]  H_ACTIVE     = H_ACTIVE_C,
  parameter logic [9:0]  H_SYNC_START = H_SYNC_START_C,
  parameter logic [9:0]  H_SYNC_END   = H_SYNC_END_C,
  parameter logic [9:0]  H_TOTAL      = H_TOTAL_C,
  parameter logic [9:0]  V_ACTIVE     = V_ACTIVE_C,
  parameter logic [9:0]  V_SYNC_START = V_SYNC_START_C,
  parameter logic [9:0]  V_SYNC_END   = V_SYNC_END_C,
  parameter logic [9:0]  V_TOTAL      = V_TOTAL_C,
  parameter int unsigned PIPE_DLY     = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic        pix_en,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic        active,
  output logic        line_tick,
  output logic        frame_tick,
  input  logic [11:0] rgb_in,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  logic       pix_q;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       line_tick_q, line_tick_d;
  logic       frame_tick_q, frame_tick_d;
  logic       hs_q, vs_q;
  rgb12_t     rgb_q;
  sync_t      sync_raw, sync_dly;
  rgb12_t     pix_colour;

  // NOTE: every signal gets a default before the branches so no latch is inferred.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_q) begin
      if (h_q == H_TOTAL - 10'd1) begin
        h_d = '0;
        v_d = (v_q == V_TOTAL - 10'd1) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Ticks are armed on the idle half of the enable so they land exactly on pix_en.
  assign line_tick_d  = !pix_q && (h_q == H_TOTAL - 10'd1);
  assign frame_tick_d = line_tick_d && (v_q == V_TOTAL - 10'd1);

  assign active      = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
  assign sync_raw.hs = !((h_q >= H_SYNC_START) && (h_q <= H_SYNC_END));
  assign sync_raw.vs = !((v_q >= V_SYNC_START) && (v_q <= V_SYNC_END));
  assign sync_raw.de = active;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned TAG_W = $bits(bar_t) + $bits(sync_t);
  logic [TAG_W-1:0] tag_dly;
  bar_t             bar_dly;
  logic             unused_rgb_in;

  vga_sync_delay #(
    .WIDTH    (TAG_W),
    .DEPTH    (PIPE_DLY),
    .RESET_VAL({BAR_WHITE, SYNC_IDLE})
  ) u_sync_delay (
    .clk_i (CLOCK_50),
    .rst_i (reset),
    .en_i  (pix_q),
    .data_i({bar_index(h_q), sync_raw}),
    .data_o(tag_dly)
  );

  assign {bar_dly, sync_dly} = tag_dly;
  assign pix_colour          = bar_colour(bar_dly);
  assign unused_rgb_in       = ^rgb_in;
`else
  logic [$bits(sync_t)-1:0] tag_dly;

  vga_sync_delay #(
    .WIDTH    ($bits(sync_t)),
    .DEPTH    (PIPE_DLY),
    .RESET_VAL(SYNC_IDLE)
  ) u_sync_delay (
    .clk_i (CLOCK_50),
    .rst_i (reset),
    .en_i  (pix_q),
    .data_i(sync_raw),
    .data_o(tag_dly)
  );

  assign sync_dly   = sync_t'(tag_dly);
  assign pix_colour = rgb12_t'(rgb_in);
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pix_q        <= 1'b0;
      h_q          <= '0;
      v_q          <= '0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      rgb_q        <= '0;
    end else begin
      pix_q        <= !pix_q;
      h_q          <= h_d;
      v_q          <= v_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
      if (pix_q) begin
        hs_q  <= sync_dly.hs;
        vs_q  <= sync_dly.vs;
        rgb_q <= sync_dly.de ? pix_colour : '0;
      end
    end
  end

  assign pix_en     = pix_q;
  assign h_count    = h_q;
  assign v_count    = v_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;
  assign VGA_R      = rgb_q.r;
  assign VGA_G      = rgb_q.g;
  assign VGA_B      = rgb_q.b;
  assign VGA_HS     = hs_q;
  assign VGA_VS     = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a full-size instance (line timing, RGB) and
// a short-frame instance (frame timing, VS, mid-frame reset) sharing clock and reset.
module tb_vga_timing_gen;

  localparam int H_TOT  = 800;
  localparam int LAT    = 2;
  localparam int SV_ACT = 4;
  localparam int SV_TOT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] rgb_in = 12'hF00;

  logic       d_pix_en, d_active, d_line_tick, d_frame_tick, d_hs, d_vs;
  logic [9:0] d_h, d_v;
  logic [3:0] d_r, d_g, d_b;
  logic       s_pix_en, s_active, s_line_tick, s_frame_tick, s_hs, s_vs;
  logic [9:0] s_h, s_v;
  logic [3:0] s_r, s_g, s_b;

  int checks = 0;
  int passed = 0;

  always #10 clk = ~clk;

  vga_timing_gen #(.PIPE_DLY(1)) dut (
    .CLOCK_50(clk), .reset(reset), .pix_en(d_pix_en), .h_count(d_h), .v_count(d_v),
    .active(d_active), .line_tick(d_line_tick), .frame_tick(d_frame_tick), .rgb_in(rgb_in),
    .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b), .VGA_HS(d_hs), .VGA_VS(d_vs)
  );

  vga_timing_gen #(
    .V_ACTIVE(10'd4), .V_SYNC_START(10'd6), .V_SYNC_END(10'd7), .V_TOTAL(10'd10), .PIPE_DLY(1)
  ) dut_s (
    .CLOCK_50(clk), .reset(reset), .pix_en(s_pix_en), .h_count(s_h), .v_count(s_v),
    .active(s_active), .line_tick(s_line_tick), .frame_tick(s_frame_tick), .rgb_in(rgb_in),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs)
  );

  function automatic logic [11:0] colour(int p);
`ifdef VGA_TEST_PATTERN_EN
    case (p / 80)
      0:       return 12'hFFF;
      1:       return 12'hFF0;
      2:       return 12'h0FF;
      3:       return 12'h0F0;
      4:       return 12'hF0F;
      5:       return 12'hF00;
      6:       return 12'h00F;
      default: return 12'h000;
    endcase
`else
    return (p >= 0) ? 12'hF00 : 12'hF00;
`endif
  endfunction

  // Expected output when the counters read (h, v): the pixel LAT positions earlier.
  function automatic logic [11:0] exp_pixel(int h, int v, int v_act, int v_tot);
    int p;
    int pv;
    p  = (h + H_TOT - LAT) % H_TOT;
    pv = (h >= LAT) ? v : (v + v_tot - 1) % v_tot;
    if (p >= 640 || pv >= v_act) return 12'h000;
    return colour(p);
  endfunction

  task automatic next_pix();
    @(negedge clk);
    if (d_pix_en !== 1'b1) @(negedge clk);
  endtask

  task automatic test_reset();
    int         bad = 0;
    logic       exp_pix [4];
    logic [9:0] exp_h [4];
    exp_pix = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_h   = '{10'd0, 10'd1, 10'd1, 10'd2};
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (d_hs !== 1'b1 || d_vs !== 1'b1 || d_pix_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL reset_hold: %0d bad cycles, required 0", bad);
    else passed++;
    checks++;
    if (d_h !== 10'd0 || d_v !== 10'd0)
      $display("FAIL reset_counts: h=%0d v=%0d, required 0/0", d_h, d_v);
    else passed++;
    checks++;
    if ({d_r, d_g, d_b, d_line_tick, d_frame_tick} !== 14'd0)
      $display("FAIL reset_outputs: rgb=%h ticks=%b%b, required 000/00", {d_r, d_g, d_b},
               d_line_tick, d_frame_tick);
    else passed++;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (d_pix_en !== exp_pix[i])
        $display("FAIL release_pix_en[%0d]: got %b, required %b", i, d_pix_en, exp_pix[i]);
      else passed++;
      checks++;
      if (d_h !== exp_h[i] || d_hs !== 1'b1 || d_vs !== 1'b1)
        $display("FAIL release_count[%0d]: h=%0d hs=%b vs=%b, required h=%0d hs=1 vs=1", i, d_h,
                 d_hs, d_vs, exp_h[i]);
      else passed++;
    end
    checks++;
    if (d_active !== 1'b1) $display("FAIL active_origin: got %b, required 1", d_active);
    else passed++;
  endtask

  task automatic test_line_tick();
    int         n = 0;
    logic [9:0] v0;
    while (d_line_tick !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 4000) $display("FAIL line_tick_timeout: waited %0d cycles, required <4000", n);
    else passed++;
    checks++;
    if (d_pix_en !== 1'b1 || d_h !== 10'd799)
      $display("FAIL line_tick_align: pix_en=%b h=%0d, required 1/799", d_pix_en, d_h);
    else passed++;
    v0 = d_v;
    @(negedge clk);
    checks++;
    if (d_line_tick !== 1'b0 || d_h !== 10'd0 || d_v !== v0 + 10'd1)
      $display("FAIL line_wrap: tick=%b h=%0d v=%0d, required 0/0/%0d", d_line_tick, d_h, d_v,
               v0 + 10'd1);
    else passed++;
  endtask

  task automatic test_hsync();
    int   lows = 0;
    int   falls = 0;
    int   fall_h = -1;
    int   rise_h = -1;
    logic prev;
    next_pix();
    prev = d_hs;
    for (int i = 0; i < H_TOT; i++) begin
      if (i > 0) next_pix();
      if (d_hs === 1'b0) lows++;
      if (prev === 1'b1 && d_hs === 1'b0) begin
        falls++;
        fall_h = int'(d_h);
      end
      if (prev === 1'b0 && d_hs === 1'b1) rise_h = int'(d_h);
      prev = d_hs;
    end
    checks++;
    if (lows != 97 || falls != 1)
      $display("FAIL hs_width: low=%0d falls=%0d, required 97/1", lows, falls);
    else passed++;
    checks++;
    if (fall_h != 662 || rise_h != 759)
      $display("FAIL hs_align: fall at h=%0d rise at h=%0d, required 662/759", fall_h, rise_h);
    else passed++;
  endtask

  task automatic test_rgb();
    int          bad = 0;
    int          first_bad = -1;
    logic [11:0] got;
    logic [11:0] spot [6];
    logic [11:0] want [6];
`ifdef VGA_TEST_PATTERN_EN
    want = '{12'hFFF, 12'hFF0, 12'h000, 12'h000, 12'h000, 12'h000};
`else
    want = '{12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'h000, 12'h000};
`endif
    for (int i = 0; i < 6; i++) spot[i] = 12'hBAD;
    for (int i = 0; i < H_TOT; i++) begin
      next_pix();
      got = {d_r, d_g, d_b};
      if (got !== exp_pixel(int'(d_h), int'(d_v), 480, 525)) begin
        bad++;
        if (first_bad < 0) first_bad = int'(d_h);
      end
      case (int'(d_h))
        2:       spot[0] = got;
        82:      spot[1] = got;
        562:     spot[2] = got;
        641:     spot[3] = got;
        642:     spot[4] = got;
        1:       spot[5] = got;
        default: ;
      endcase
    end
    checks++;
    if (bad != 0) $display("FAIL rgb_line: %0d wrong pixels, first at h=%0d, required 0", bad, first_bad);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (spot[i] !== want[i]) $display("FAIL rgb_spot[%0d]: got %h, required %h", i, spot[i], want[i]);
      else passed++;
    end
  endtask

  task automatic test_frame();
    int         n = 0;
    int         pix = 0, lines = 0, frames = 0, orphan = 0;
    int         hs_low = 0, vs_low = 0, bad = 0;
    int         vs_fall_h = -1, vs_fall_v = -1;
    logic [9:0] hmax = '0, vmax = '0;
    while (s_frame_tick !== 1'b1 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40000) $display("FAIL frame_tick_timeout: waited %0d cycles, required <40000", n);
    else passed++;
    checks++;
    if (s_line_tick !== 1'b1 || s_pix_en !== 1'b1 || s_h !== 10'd799 || s_v !== 10'd9)
      $display("FAIL frame_tick_align: line_tick=%b pix_en=%b h=%0d v=%0d, required 1/1/799/9",
               s_line_tick, s_pix_en, s_h, s_v);
    else passed++;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (s_frame_tick === 1'b1) frames++;
      if (s_frame_tick === 1'b1 && s_line_tick !== 1'b1) orphan++;
      if (s_line_tick === 1'b1) lines++;
      if (s_pix_en === 1'b1) begin
        pix++;
        if (s_h > hmax) hmax = s_h;
        if (s_v > vmax) vmax = s_v;
        if (s_hs === 1'b0) hs_low++;
        if (s_vs === 1'b0) begin
          vs_low++;
          if (vs_low == 1) begin
            vs_fall_h = int'(s_h);
            vs_fall_v = int'(s_v);
          end
        end
        if ({s_r, s_g, s_b} !== exp_pixel(int'(s_h), int'(s_v), SV_ACT, SV_TOT)) bad++;
      end
    end while (s_frame_tick !== 1'b1 && n < 40000);
    checks++;
    if (pix != H_TOT * SV_TOT) $display("FAIL frame_pixels: got %0d, required %0d", pix, H_TOT * SV_TOT);
    else passed++;
    checks++;
    if (lines != SV_TOT || frames != 1 || orphan != 0)
      $display("FAIL frame_ticks: lines=%0d frames=%0d orphan=%0d, required 10/1/0", lines, frames, orphan);
    else passed++;
    checks++;
    if (hmax !== 10'd799 || vmax !== 10'd9)
      $display("FAIL count_peaks: h=%0d v=%0d, required 799/9", hmax, vmax);
    else passed++;
    checks++;
    if (hs_low != 97 * SV_TOT) $display("FAIL frame_hs_low: got %0d, required %0d", hs_low, 97 * SV_TOT);
    else passed++;
    checks++;
    if (vs_low != 2 * H_TOT || vs_fall_h != 2 || vs_fall_v != 6)
      $display("FAIL vs_pulse: low=%0d first at h=%0d v=%0d, required 1600 at 2/6", vs_low,
               vs_fall_h, vs_fall_v);
    else passed++;
    checks++;
    if (bad != 0) $display("FAIL frame_blanking: %0d wrong pixels, required 0", bad);
    else passed++;
  endtask

  task automatic test_mid_frame_reset();
    int n = 0;
    int hs_low = 0, vs_low = 0;
    while (!(s_pix_en === 1'b1 && s_h === 10'd700 && s_v === 10'd6) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40000) $display("FAIL mid_reset_timeout: waited %0d cycles, required <40000", n);
    else passed++;
    checks++;
    if (s_hs !== 1'b0 || s_vs !== 1'b0)
      $display("FAIL pre_reset_sync: hs=%b vs=%b, required 0/0", s_hs, s_vs);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (s_hs !== 1'b1 || s_vs !== 1'b1 || s_h !== 10'd0 || s_v !== 10'd0 || d_h !== 10'd0)
      $display("FAIL mid_reset_state: hs=%b vs=%b h=%0d v=%0d dh=%0d, required 1/1/0/0/0", s_hs,
               s_vs, s_h, s_v, d_h);
    else passed++;
    checks++;
    if ({s_r, s_g, s_b, s_pix_en, s_line_tick, s_frame_tick} !== 15'd0)
      $display("FAIL mid_reset_outputs: rgb=%h pix=%b ticks=%b%b, required 000/0/00", {s_r, s_g, s_b},
               s_pix_en, s_line_tick, s_frame_tick);
    else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!(s_pix_en === 1'b1 && s_h === 10'd661) && n < 4000) begin
      @(negedge clk);
      n++;
      if (s_hs === 1'b0) hs_low++;
      if (s_vs === 1'b0) vs_low++;
    end
    checks++;
    if (n >= 4000 || hs_low != 0 || vs_low != 0)
      $display("FAIL post_reset_glitch: hs_low=%0d vs_low=%0d wait=%0d, required 0/0/<4000", hs_low,
               vs_low, n);
    else passed++;
    next_pix();
    checks++;
    if (s_h !== 10'd662 || s_hs !== 1'b0)
      $display("FAIL post_reset_hs: h=%0d hs=%b, required 662/0", s_h, s_hs);
    else passed++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_line_tick();
    test_hsync();
    test_rgb();
    test_frame();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
